// File: rtl/npcnn_pkg.sv
// Shared constants, FSM state type and geometry helpers for the npcnn result sink.
package npcnn_pkg;

  localparam int DW = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  function automatic int out_size(input int a_size, input int f_size,
                                  input int stride, input int zeropadding);
    return (a_size - f_size + 2 * zeropadding) / stride + 1;
  endfunction

  // An address bus is never narrower than one bit, even for a 1-word map.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npcnn_result_sink_if.sv
// Engine-stream, host-readback and status signals of the result sink in one bundle.
interface npcnn_result_sink_if #(
  parameter int DW = 20,
  parameter int AW = 4,
  parameter int CW = 5
);
  logic          arm;
  logic [DW-1:0] in_data;
  logic          in_vld;
  logic          in_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          busy;
  logic          ready;
  logic [CW-1:0] count;
  logic          err_overflow;
  logic          err_short;

  modport master (
    output arm, in_data, in_vld, in_done, rd_en, rd_addr,
    input  rd_data, rd_vld, busy, ready, count, err_overflow, err_short
  );

  modport slave (
    input  arm, in_data, in_vld, in_done, rd_en, rd_addr,
    output rd_data, rd_vld, busy, ready, count, err_overflow, err_short
  );
endinterface

// File: rtl/npcnn_obuf.sv
// Feature-map buffer: simple dual-port RAM, synchronous write, registered read-before-write.
module npcnn_obuf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; consumers gate stale words instead.
  always_ff @(posedge clk) begin
    if (we && int'(waddr) < DEPTH) mem[waddr] <= wdata;
    if (re && int'(raddr) < DEPTH) rdata <= mem[raddr];
  end

endmodule

// File: rtl/npcnn_result_sink.sv
// Captures one raster frame of convolution results, flags protocol errors, serves host reads.
module npcnn_result_sink
  import npcnn_pkg::*;
#(
  parameter int a_size      = 6,
  parameter int f_size      = 3,
  parameter int stride      = 1,
  parameter int zeropadding = 0,
  parameter int DW          = npcnn_pkg::DW
) (
  input logic                clk,
  input logic                reset,
  npcnn_result_sink_if.slave bus
);

  localparam int O_SIZE = out_size(a_size, f_size, stride, zeropadding);
  localparam int N      = O_SIZE * O_SIZE;
  localparam int AW     = addr_width(N);
  localparam int CW     = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_o_q, err_o_d;
  logic          err_s_q, err_s_d;
  logic          busy_q, ready_q;
  logic          rd_vld_q, rd_ok_q;
  logic          wr_en;
  logic [DW-1:0] ram_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_o_d = err_o_q;
    err_s_d = err_s_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d = CAPTURE;
          count_d = '0;
          err_o_d = 1'b0;
          err_s_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (bus.arm) begin
          // Restart wins over a coincident word, which is dropped.
          count_d = '0;
          err_o_d = 1'b0;
          err_s_d = 1'b0;
        end else begin
          if (bus.in_vld && count_q != N_C) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
          if (count_d == N_C) begin
            state_d = READY;
          end else if (bus.in_done) begin
            err_s_d = 1'b1;
            state_d = READY;
          end
        end
      end
      READY: begin
        if (bus.arm) begin
          state_d = CAPTURE;
          count_d = '0;
          err_o_d = 1'b0;
          err_s_d = 1'b0;
        end else if (bus.in_vld) begin
          err_o_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      err_o_q  <= 1'b0;
      err_s_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_o_q  <= err_o_d;
      err_s_q  <= err_s_d;
      busy_q   <= (state_d == CAPTURE);
      ready_q  <= (state_d == READY);
      rd_vld_q <= bus.rd_en;
      // Addresses not yet written in this frame read back as zero.
      if (bus.rd_en)
        rd_ok_q <= (int'(bus.rd_addr) < N) && (int'(bus.rd_addr) < int'(count_q));
    end
  end

  npcnn_obuf #(.DEPTH(N), .AW(AW), .DW(DW)) u_obuf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (bus.in_data),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (ram_q)
  );

  assign bus.rd_data      = rd_ok_q ? ram_q : '0;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.busy         = busy_q;
  assign bus.ready        = ready_q;
  assign bus.count        = count_q;
  assign bus.err_overflow = err_o_q;
  assign bus.err_short    = err_s_q;

endmodule

// File: tb/tb_npcnn_result_sink.sv
// Self-checking bench for npcnn_result_sink: vector table, directed frames, random traffic vs model.
module tb_npcnn_result_sink;

  localparam int A_SIZE = 6;
  localparam int F_SIZE = 3;
  localparam int STRIDE = 1;
  localparam int ZP     = 0;
  localparam int DW     = 20;
  localparam int O_SIZE = (A_SIZE - F_SIZE + 2 * ZP) / STRIDE + 1;
  localparam int N      = O_SIZE * O_SIZE;
  localparam int AW     = $clog2(N);
  localparam int CW     = $clog2(N + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npcnn_result_sink_if #(.DW(DW), .AW(AW), .CW(CW)) sink_if ();

  npcnn_result_sink #(
    .a_size(A_SIZE), .f_size(F_SIZE), .stride(STRIDE), .zeropadding(ZP), .DW(DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sink_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame as an array plus a word count and two phase flags.
  logic [DW-1:0] m_mem [N];
  int            m_count;
  bit            m_capturing, m_holding, m_err_o, m_err_s, m_rd_vld;
  logic [DW-1:0] m_rd_data;

  task automatic model_edge(input bit r, input bit a, input bit v, input logic [DW-1:0] d,
                            input bit dn, input bit re, input int ad);
    if (re) m_rd_data = (ad < m_count) ? m_mem[ad] : '0;
    m_rd_vld = re;
    if (r) begin
      m_capturing = 0; m_holding = 0; m_count = 0;
      m_err_o = 0; m_err_s = 0; m_rd_vld = 0; m_rd_data = '0;
    end else if (a) begin
      m_capturing = 1; m_holding = 0; m_count = 0; m_err_o = 0; m_err_s = 0;
    end else if (m_capturing) begin
      if (v) begin
        m_mem[m_count] = d;
        m_count++;
      end
      if (m_count == N) begin
        m_capturing = 0; m_holding = 1;
      end else if (dn) begin
        m_err_s = 1; m_capturing = 0; m_holding = 1;
      end
    end else if (m_holding && v) begin
      m_err_o = 1;
    end
  endtask

  task automatic compare_model();
    check("busy", 32'(sink_if.busy), 32'(m_capturing));
    check("ready", 32'(sink_if.ready), 32'(m_holding));
    check("count", 32'(sink_if.count), 32'(m_count));
    check("err_overflow", 32'(sink_if.err_overflow), 32'(m_err_o));
    check("err_short", 32'(sink_if.err_short), 32'(m_err_s));
    check("rd_vld", 32'(sink_if.rd_vld), 32'(m_rd_vld));
    if (m_rd_vld) check("rd_data", 32'(sink_if.rd_data), 32'(m_rd_data));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic step(input bit r, input bit a, input bit v, input logic [DW-1:0] d,
                      input bit dn, input bit re, input int ad);
    reset           = r;
    sink_if.arm     = a;
    sink_if.in_vld  = v;
    sink_if.in_data = d;
    sink_if.in_done = dn;
    sink_if.rd_en   = re;
    sink_if.rd_addr = AW'(ad);
    @(posedge clk);
    #1;
    model_edge(r, a, v, d, dn, re, ad);
    compare_model();
  endtask

  task automatic idle();                    step(0, 0, 0, '0, 0, 0, 0); endtask
  task automatic do_reset();                step(1, 0, 0, '0, 0, 0, 0); endtask
  task automatic do_arm();                  step(0, 1, 0, '0, 0, 0, 0); endtask
  task automatic put(input logic [DW-1:0] d); step(0, 0, 1, d, 0, 0, 0); endtask
  task automatic rd(input int ad);          step(0, 0, 0, '0, 0, 1, ad); endtask

  typedef struct {
    bit            arm, vld;
    logic [DW-1:0] data;
    bit            done, rd;
    int            addr;
    bit            busy, ready;
    int            count;
    bit            err_o, err_s, rd_vld;
    logic [DW-1:0] rd_data;
  } vec_t;

  vec_t vt[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            arm vld data      done rd addr busy rdy cnt eo es rv rdata
    vt[0]  = '{1, 0, 20'h00000, 0, 0, 0,  1, 0, 0, 0, 0, 0, 20'h00000};
    vt[1]  = '{0, 1, 20'h12345, 0, 0, 0,  1, 0, 1, 0, 0, 0, 20'h00000};
    vt[2]  = '{0, 1, 20'hABCDE, 0, 0, 0,  1, 0, 2, 0, 0, 0, 20'h00000};
    vt[3]  = '{0, 0, 20'h00000, 1, 1, 0,  0, 1, 2, 0, 1, 1, 20'h12345};
    vt[4]  = '{0, 0, 20'h00000, 0, 1, 1,  0, 1, 2, 0, 1, 1, 20'hABCDE};
    vt[5]  = '{0, 0, 20'h00000, 0, 1, 2,  0, 1, 2, 0, 1, 1, 20'h00000};
    vt[6]  = '{0, 1, 20'hFFFFF, 0, 0, 0,  0, 1, 2, 1, 1, 0, 20'h00000};
    vt[7]  = '{0, 0, 20'h00000, 1, 0, 0,  0, 1, 2, 1, 1, 0, 20'h00000};
    vt[8]  = '{1, 0, 20'h00000, 0, 0, 0,  1, 0, 0, 0, 0, 0, 20'h00000};
    vt[9]  = '{0, 1, 20'h00777, 0, 1, 0,  1, 0, 1, 0, 0, 1, 20'h00000};
    vt[10] = '{0, 0, 20'h00000, 0, 1, 0,  1, 0, 1, 0, 0, 1, 20'h00777};

    do_reset();
    do_reset();
    check("rst_busy", 32'(sink_if.busy), 32'd0);
    check("rst_ready", 32'(sink_if.ready), 32'd0);
    check("rst_count", 32'(sink_if.count), 32'd0);
    check("rst_rd_data", 32'(sink_if.rd_data), 32'd0);
    check("rst_rd_vld", 32'(sink_if.rd_vld), 32'd0);
    idle();
    put(20'h55555);
    check("idle_vld_ignored", 32'(sink_if.count), 32'd0);
    check("idle_no_overflow", 32'(sink_if.err_overflow), 32'd0);

    for (int i = 0; i < 11; i++) begin
      step(0, vt[i].arm, vt[i].vld, vt[i].data, vt[i].done, vt[i].rd, vt[i].addr);
      check($sformatf("vec%0d_busy", i), 32'(sink_if.busy), 32'(vt[i].busy));
      check($sformatf("vec%0d_ready", i), 32'(sink_if.ready), 32'(vt[i].ready));
      check($sformatf("vec%0d_count", i), 32'(sink_if.count), 32'(vt[i].count));
      check($sformatf("vec%0d_err_o", i), 32'(sink_if.err_overflow), 32'(vt[i].err_o));
      check($sformatf("vec%0d_err_s", i), 32'(sink_if.err_short), 32'(vt[i].err_s));
      check($sformatf("vec%0d_rd_vld", i), 32'(sink_if.rd_vld), 32'(vt[i].rd_vld));
      if (vt[i].rd_vld)
        check($sformatf("vec%0d_rd_data", i), 32'(sink_if.rd_data), 32'(vt[i].rd_data));
    end

    // Full frame, then back-to-back readback.
    do_reset();
    do_arm();
    for (int i = 0; i < N; i++) begin
      put(DW'(i + 1));
      if (i == N - 2) check("full_not_ready_early", 32'(sink_if.ready), 32'd0);
    end
    check("full_ready", 32'(sink_if.ready), 32'd1);
    check("full_count", 32'(sink_if.count), 32'(N));
    check("full_err_short", 32'(sink_if.err_short), 32'd0);
    for (int i = 0; i < N; i++) begin
      rd(i);
      check($sformatf("full_rd%0d_vld", i), 32'(sink_if.rd_vld), 32'd1);
      check($sformatf("full_rd%0d", i), 32'(sink_if.rd_data), 32'(i + 1));
    end
    idle();
    check("rd_vld_pulse", 32'(sink_if.rd_vld), 32'd0);

    // Overflow after a full frame leaves the buffer intact.
    put(20'hFFFFF);
    check("ovf_flag", 32'(sink_if.err_overflow), 32'd1);
    rd(15);
    check("ovf_buf_intact", 32'(sink_if.rd_data), 32'h00010);

    // Short frame.
    do_arm();
    for (int i = 0; i < 10; i++) put(DW'(20'h00300 + i));
    step(0, 0, 0, '0, 1, 0, 0);
    check("short_err", 32'(sink_if.err_short), 32'd1);
    check("short_ready", 32'(sink_if.ready), 32'd1);
    check("short_count", 32'(sink_if.count), 32'd10);
    rd(12);
    check("short_rd_beyond", 32'(sink_if.rd_data), 32'd0);
    rd(9);
    check("short_rd_last", 32'(sink_if.rd_data), 32'h00309);

    // Last word and done in the same cycle.
    do_arm();
    for (int i = 0; i < N - 1; i++) put(DW'(i));
    step(0, 0, 1, 20'h0BEEF, 1, 0, 0);
    check("last_done_ready", 32'(sink_if.ready), 32'd1);
    check("last_done_no_err", 32'(sink_if.err_short), 32'd0);
    check("last_done_count", 32'(sink_if.count), 32'(N));

    // Re-arm mid-capture, with a word dropped alongside the arm.
    do_arm();
    for (int i = 0; i < 5; i++) put(DW'(20'h00900 + i));
    step(0, 1, 1, 20'h0DEAD, 0, 0, 0);
    check("rearm_count", 32'(sink_if.count), 32'd0);
    for (int i = 0; i < N; i++) put(DW'(20'h000A0 + i));
    check("rearm_full_count", 32'(sink_if.count), 32'(N));
    rd(0);
    check("rearm_rd0", 32'(sink_if.rd_data), 32'h000A0);
    check("rearm_no_err", 32'({sink_if.err_overflow, sink_if.err_short}), 32'd0);

    // Reset in the middle of a capture.
    do_arm();
    for (int i = 0; i < 7; i++) put(DW'(i));
    do_reset();
    check("midrst_busy", 32'(sink_if.busy), 32'd0);
    check("midrst_count", 32'(sink_if.count), 32'd0);
    check("midrst_flags", 32'({sink_if.ready, sink_if.err_overflow, sink_if.err_short}), 32'd0);
    idle();
    do_arm();
    for (int i = 0; i < N; i++) put(DW'(20'h00C00 + i));
    check("midrst_recover_ready", 32'(sink_if.ready), 32'd1);
    check("midrst_recover_count", 32'(sink_if.count), 32'(N));
    rd(N - 1);
    check("midrst_recover_rd", 32'(sink_if.rd_data), 32'(20'h00C00 + N - 1));

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           DW'($urandom), $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, N - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
